dcache_line_controller: RTL and testbench
=========================================

Name: dcache_line_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache sitting between the CPU load/store port and the bulk line-transfer port that feeds the AXI bulk adapter.
- Serves single-word (64-bit) CPU accesses from a flop-based line store.
- On a miss, evicts a dirty victim as one bulk line write, then refills with one bulk line read.
- Issues at most one bulk request at a time.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 64, word width; must match the bulk adapter beat width.
- LINE_WORDS, 8, words per line; must match the adapter LINE_SIZE.
- NUM_LINES, 16, number of cache lines; power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cpu_req_valid  in  1  CPU request valid.
- cpu_req_ready  out  1  controller accepts a request; high only in S_IDLE.
- cpu_req_write  in  1  1 = store, 0 = load.
- cpu_req_addr  in  ADDR_W  byte address; bits [2:0] ignored.
- cpu_req_wdata  in  DATA_W  store data.
- cpu_req_wstrb  in  DATA_W/8  store byte enables.
- cpu_resp_valid  out  1  one-cycle response pulse.
- cpu_resp_rdata  out  DATA_W  load data; for stores, the merged word.
- bulk_req_valid  out  1  line request valid.
- bulk_req_ready  in  1  adapter accepts the request.
- bulk_req_write  out  1  1 = writeback, 0 = refill.
- bulk_req_addr  out  ADDR_W  line-aligned address.
- bulk_req_wdata  out  LINE_WORDS*DATA_W  victim line, word 0 in the LSBs.
- bulk_req_wstrb  out  LINE_WORDS*DATA_W/8  always all-ones.
- bulk_resp_valid  in  1  refill data valid (single-cycle pulse).
- bulk_resp_rdata  in  LINE_WORDS*DATA_W  refill line.

Behaviour:
- Address split: offset = log2(DATA_W/8) + log2(LINE_WORDS) bits (6); index = log2(NUM_LINES) bits (4); tag = the remaining bits (22).
- Storage per line: valid, dirty, tag, data. Reset clears every valid and dirty bit; data and tags are not reset.
- Reset values: all outputs 0, state S_IDLE.
- Reset mid-operation: any pending bulk request is abandoned, no CPU response is produced. rst is shared with the adapter.
- S_IDLE:
  - cpu_req_ready = 1.
  - On cpu_req_valid, latch addr/write/wdata/wstrb and go to S_LOOKUP.
- S_LOOKUP:
  - Hit = valid && tag match.
  - Load hit: register the word selected by the word offset and pulse cpu_resp_valid the following cycle (S_RESP).
  - Store hit: merge wdata into the word under wstrb, set dirty, and respond with the merged word the same way.
  - Miss with victim valid && dirty: go to S_WB.
  - Miss otherwise: go to S_FILL_REQ.
- S_WB:
  - bulk_req_valid = 1, bulk_req_write = 1.
  - addr = {victim tag, index, 0}; wdata = victim line; wstrb all-ones.
  - Hold all fields stable until bulk_req_ready, then go to S_FILL_REQ. No response is expected for writes.
- S_FILL_REQ:
  - bulk_req_valid = 1, bulk_req_write = 0, addr = {req tag, index, 0}, wdata/wstrb = 0.
  - Hold until bulk_req_ready, then go to S_FILL_WAIT.
- S_FILL_WAIT:
  - On bulk_resp_valid, write the line, set valid, clear dirty, update tag, then go to S_LOOKUP. The replay is a guaranteed hit.
  - bulk_resp_valid in any other state is ignored.
- S_RESP: cpu_resp_valid = 1 for exactly one cycle, then go to S_IDLE.
- Latency:
  - Hit: request accepted at cycle T, response at T+2; next request accepted at T+3.
  - Miss: adapter latency plus 4 cycles (plus the writeback handshake if the victim is dirty).
- bulk_req_valid never deasserts before the handshake completes, and never asserts in S_IDLE, S_LOOKUP, S_RESP or S_FILL_WAIT.
- A store miss allocates the line and then merges on replay; the line ends dirty.

Decomposition:
- dcache_pkg holds:
  - the state enum;
  - localparams OFFSET_W, INDEX_W, TAG_W and LINE_BITS derived from the parameters;
  - helper functions to extract tag/index/word offset from an address and to merge a word under wstrb.
- One sub-module, dcache_line_store: valid/dirty/tag/data arrays with combinational read by index, a one-cycle synchronous full-line write (refill), a word write (store hit), and a valid clear on rst.

Test Plan:
- Cold load 0x0000_1008 after reset:
  - Required: bulk read at 0x0000_1000, no writeback.
  - Refill word1 = 0xAAAA_0001 -> cpu_resp_rdata = 0xAAAA_0001.
- Load hit 0x0000_1010 after that refill:
  - Required: cpu_resp_valid exactly 2 cycles after acceptance, with refill word2.
  - No bulk_req_valid activity.
- Store 0x0000_1000, wdata 0x1122334455667788, wstrb 0x0F, on a line whose word0 = 0:
  - Required: response = 0x0000000055667788; line marked dirty.
- Conflict load 0x0000_1400 (same index, new tag) after the dirty store:
  - Required: bulk write at 0x0000_1000 first, with word0 = 0x0000000055667788 and wstrb all-ones.
  - Then bulk read at 0x0000_1400.
- bulk_req_ready held low for 5 cycles during S_WB:
  - Required: bulk_req_valid and all request fields constant; cpu_req_ready = 0 throughout.
- rst asserted during S_FILL_WAIT:
  - Required: next cycle all outputs 0 and cpu_req_ready = 1 once rst is released.
  - A later load to the same address misses again.

Source files
------------

// File: rtl/dcache_line_controller_pkg.sv
// dcache_pkg: shared types, geometry and helpers for the data-cache line
// controller.
//   - dcache_state_e : controller FSM states
//   - geometry       : ADDR_W, DATA_W, LINE_WORDS, NUM_LINES and the derived
//                      OFFSET_W / INDEX_W / TAG_W / LINE_BITS widths
//   - helpers        : address field extraction, line address rebuild and
//                      byte-enable word merge
package dcache_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 64;  // must equal the bulk adapter beat width
  localparam int LINE_WORDS = 8;   // must equal the bulk adapter LINE_SIZE
  localparam int NUM_LINES  = 16;  // power of two

  localparam int STRB_W      = DATA_W / 8;
  localparam int BYTE_OFF_W  = $clog2(STRB_W);
  localparam int WORD_OFF_W  = $clog2(LINE_WORDS);
  localparam int OFFSET_W    = BYTE_OFF_W + WORD_OFF_W;
  localparam int INDEX_W     = $clog2(NUM_LINES);
  localparam int TAG_W       = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_BITS   = LINE_WORDS * DATA_W;
  localparam int LINE_STRB_W = LINE_BITS / 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WB        = 3'd2,
    S_FILL_REQ  = 3'd3,
    S_FILL_WAIT = 3'd4,
    S_RESP      = 3'd5
  } dcache_state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [WORD_OFF_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
    return a[BYTE_OFF_W +: WORD_OFF_W];
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [INDEX_W-1:0] index);
    return {tag, index, {OFFSET_W{1'b0}}};
  endfunction

  // Byte-wise merge: bytes with a set strobe come from wdata, the rest
  // keep the old word.
  function automatic logic [DATA_W-1:0] merge_word(input logic [DATA_W-1:0] old_word,
                                                   input logic [DATA_W-1:0] wdata,
                                                   input logic [STRB_W-1:0] wstrb);
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int b = 0; b < STRB_W; b++) begin
      if (wstrb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_line_controller_if.sv
// Bus interfaces of the data-cache line controller.
//   dcache_cpu_if  : CPU load/store port. master = CPU, slave = cache.
//   dcache_bulk_if : line-transfer port to the bulk adapter.
//                    master = cache, slave = adapter.
// Handshake rule for both request channels: a transfer happens on a rising
// clk edge where valid and ready are both high; once valid is raised the
// master holds it and every request field stable until that edge. Response
// signals (cpu_resp_valid, bulk_resp_valid) are single-cycle pulses with no
// back-pressure.
interface dcache_cpu_if;
  import dcache_pkg::*;

  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic              cpu_req_write;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic [DATA_W-1:0] cpu_req_wdata;
  logic [STRB_W-1:0] cpu_req_wstrb;
  logic              cpu_resp_valid;
  logic [DATA_W-1:0] cpu_resp_rdata;

  modport master (
    output cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata, cpu_req_wstrb,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata
  );

  modport slave (
    input  cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata, cpu_req_wstrb,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata
  );
endinterface

interface dcache_bulk_if;
  import dcache_pkg::*;

  logic                   bulk_req_valid;
  logic                   bulk_req_ready;
  logic                   bulk_req_write;
  logic [ADDR_W-1:0]      bulk_req_addr;
  logic [LINE_BITS-1:0]   bulk_req_wdata;
  logic [LINE_STRB_W-1:0] bulk_req_wstrb;
  logic                   bulk_resp_valid;
  logic [LINE_BITS-1:0]   bulk_resp_rdata;

  modport master (
    output bulk_req_valid, bulk_req_write, bulk_req_addr, bulk_req_wdata, bulk_req_wstrb,
    input  bulk_req_ready, bulk_resp_valid, bulk_resp_rdata
  );

  modport slave (
    input  bulk_req_valid, bulk_req_write, bulk_req_addr, bulk_req_wdata, bulk_req_wstrb,
    output bulk_req_ready, bulk_resp_valid, bulk_resp_rdata
  );
endinterface

// File: rtl/dcache_line_controller_line_store.sv
// dcache_line_store: flop-based storage for the direct-mapped cache.
// Per line: valid, dirty, tag and LINE_WORDS data words.
//   clk, rst      : clock, synchronous active-high reset (clears valid/dirty
//                   only; tags and data are left as they are)
//   index_i       : line selected for the combinational read and for writes
//   rd_*_o        : contents of the selected line, word 0 in the LSBs
//   fill_en_i     : full-line refill; sets valid, clears dirty, loads tag
//   word_we_i     : single word write at word_off_i; sets dirty
module dcache_line_store
  import dcache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_W-1:0]    index_i,
  output logic                  rd_valid_o,
  output logic                  rd_dirty_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [LINE_BITS-1:0]  rd_line_o,
  input  logic                  fill_en_i,
  input  logic [TAG_W-1:0]      fill_tag_i,
  input  logic [LINE_BITS-1:0]  fill_line_i,
  input  logic                  word_we_i,
  input  logic [WORD_OFF_W-1:0] word_off_i,
  input  logic [DATA_W-1:0]     word_data_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];

  assign rd_valid_o = valid_q[index_i];
  assign rd_dirty_o = dirty_q[index_i];
  assign rd_tag_o   = tag_q[index_i];
  assign rd_line_o  = data_q[index_i];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en_i) begin
      valid_q[index_i] <= 1'b1;
      dirty_q[index_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[index_i] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[index_i]  <= fill_tag_i;
      data_q[index_i] <= fill_line_i;
    end else if (word_we_i) begin
      data_q[index_i][int'(word_off_i)*DATA_W +: DATA_W] <= word_data_i;
    end
  end

endmodule

// File: rtl/dcache_line_controller.sv
// dcache_line_controller: direct-mapped, write-back, write-allocate data
// cache between the CPU load/store port and the bulk line-transfer port.
//   clk, rst : clock, synchronous active-high reset (shared with the adapter)
//   cpu      : CPU request/response port (slave side)
//   bulk     : line writeback/refill port to the bulk adapter (master side)
//   state_o  : current FSM state, for observation
// A miss on a dirty victim writes the victim line back first, then refills;
// the refilled request is replayed through S_LOOKUP where it always hits.
module dcache_line_controller
  import dcache_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  dcache_cpu_if.slave   cpu,
  dcache_bulk_if.master bulk,
  output dcache_state_e state_o
);

  dcache_state_e          state_q;

  // Latched request
  logic                   req_write_q;
  logic [TAG_W-1:0]       req_tag_q;
  logic [INDEX_W-1:0]     req_index_q;
  logic [WORD_OFF_W-1:0]  req_word_q;
  logic [DATA_W-1:0]      req_wdata_q;
  logic [STRB_W-1:0]      req_wstrb_q;

  // Registered outputs
  logic                   cpu_req_ready_q;
  logic                   cpu_resp_valid_q;
  logic [DATA_W-1:0]      cpu_resp_rdata_q;
  logic                   bulk_req_valid_q;
  logic                   bulk_req_write_q;
  logic [ADDR_W-1:0]      bulk_req_addr_q;
  logic [LINE_BITS-1:0]   bulk_req_wdata_q;
  logic [LINE_STRB_W-1:0] bulk_req_wstrb_q;

  // Line store view of the latched index
  logic                   rd_valid;
  logic                   rd_dirty;
  logic [TAG_W-1:0]       rd_tag;
  logic [LINE_BITS-1:0]   rd_line;

  logic                   hit;
  logic [DATA_W-1:0]      hit_word;
  logic [DATA_W-1:0]      merged_word;
  logic                   word_we;
  logic                   fill_en;

  assign hit         = rd_valid && (rd_tag == req_tag_q);
  assign hit_word    = rd_line[int'(req_word_q)*DATA_W +: DATA_W];
  assign merged_word = merge_word(hit_word, req_wdata_q, req_wstrb_q);
  assign word_we     = (state_q == S_LOOKUP) && hit && req_write_q;
  assign fill_en     = (state_q == S_FILL_WAIT) && bulk.bulk_resp_valid;

  dcache_line_store u_store (
    .clk         (clk),
    .rst         (rst),
    .index_i     (req_index_q),
    .rd_valid_o  (rd_valid),
    .rd_dirty_o  (rd_dirty),
    .rd_tag_o    (rd_tag),
    .rd_line_o   (rd_line),
    .fill_en_i   (fill_en),
    .fill_tag_i  (req_tag_q),
    .fill_line_i (bulk.bulk_resp_rdata),
    .word_we_i   (word_we),
    .word_off_i  (req_word_q),
    .word_data_i (merged_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      req_write_q      <= 1'b0;
      req_tag_q        <= '0;
      req_index_q      <= '0;
      req_word_q       <= '0;
      req_wdata_q      <= '0;
      req_wstrb_q      <= '0;
      cpu_req_ready_q  <= 1'b0;
      cpu_resp_valid_q <= 1'b0;
      cpu_resp_rdata_q <= '0;
      bulk_req_valid_q <= 1'b0;
      bulk_req_write_q <= 1'b0;
      bulk_req_addr_q  <= '0;
      bulk_req_wdata_q <= '0;
      bulk_req_wstrb_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Ready is registered, so the first idle cycle after reset does
          // not accept; acceptance needs the already-visible ready.
          cpu_req_ready_q <= 1'b1;
          if (cpu_req_ready_q && cpu.cpu_req_valid) begin
            req_write_q     <= cpu.cpu_req_write;
            req_tag_q       <= addr_tag(cpu.cpu_req_addr);
            req_index_q     <= addr_index(cpu.cpu_req_addr);
            req_word_q      <= addr_word(cpu.cpu_req_addr);
            req_wdata_q     <= cpu.cpu_req_wdata;
            req_wstrb_q     <= cpu.cpu_req_wstrb;
            cpu_req_ready_q <= 1'b0;
            state_q         <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          if (hit) begin
            cpu_resp_valid_q <= 1'b1;
            cpu_resp_rdata_q <= req_write_q ? merged_word : hit_word;
            state_q          <= S_RESP;
          end else if (rd_valid && rd_dirty) begin
            bulk_req_valid_q <= 1'b1;
            bulk_req_write_q <= 1'b1;
            bulk_req_addr_q  <= line_addr(rd_tag, req_index_q);
            bulk_req_wdata_q <= rd_line;
            bulk_req_wstrb_q <= '1;
            state_q          <= S_WB;
          end else begin
            bulk_req_valid_q <= 1'b1;
            bulk_req_write_q <= 1'b0;
            bulk_req_addr_q  <= line_addr(req_tag_q, req_index_q);
            bulk_req_wdata_q <= '0;
            bulk_req_wstrb_q <= '0;
            state_q          <= S_FILL_REQ;
          end
        end

        S_WB: begin
          // Writeback accepted: switch straight to the refill request,
          // keeping valid high.
          if (bulk.bulk_req_ready) begin
            bulk_req_write_q <= 1'b0;
            bulk_req_addr_q  <= line_addr(req_tag_q, req_index_q);
            bulk_req_wdata_q <= '0;
            bulk_req_wstrb_q <= '0;
            state_q          <= S_FILL_REQ;
          end
        end

        S_FILL_REQ: begin
          if (bulk.bulk_req_ready) begin
            bulk_req_valid_q <= 1'b0;
            bulk_req_addr_q  <= '0;
            state_q          <= S_FILL_WAIT;
          end
        end

        S_FILL_WAIT: begin
          // The line store takes the refill on this edge; replay the lookup.
          if (bulk.bulk_resp_valid) state_q <= S_LOOKUP;
        end

        S_RESP: begin
          cpu_resp_valid_q <= 1'b0;
          cpu_resp_rdata_q <= '0;
          cpu_req_ready_q  <= 1'b1;
          state_q          <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu.cpu_req_ready   = cpu_req_ready_q;
  assign cpu.cpu_resp_valid  = cpu_resp_valid_q;
  assign cpu.cpu_resp_rdata  = cpu_resp_rdata_q;
  assign bulk.bulk_req_valid = bulk_req_valid_q;
  assign bulk.bulk_req_write = bulk_req_write_q;
  assign bulk.bulk_req_addr  = bulk_req_addr_q;
  assign bulk.bulk_req_wdata = bulk_req_wdata_q;
  assign bulk.bulk_req_wstrb = bulk_req_wstrb_q;
  assign state_o             = state_q;

endmodule

// File: tb/tb_dcache_line_controller.sv
// Testbench for dcache_line_controller: directed CPU accesses, a bulk
// adapter model with configurable stall and latency, and a negedge monitor
// that checks CPU responses and bulk requests against expected queues.
module tb_dcache_line_controller;
  import dcache_pkg::*;

  typedef struct packed {
    logic                   write;
    logic [ADDR_W-1:0]      addr;
    logic [LINE_BITS-1:0]   wdata;
    logic [LINE_STRB_W-1:0] wstrb;
  } bulk_exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  dcache_cpu_if  cpu_if ();
  dcache_bulk_if bulk_if ();
  dcache_state_e state;

  dcache_line_controller dut (
    .clk     (clk),
    .rst     (rst),
    .cpu     (cpu_if.slave),
    .bulk    (bulk_if.master),
    .state_o (state)
  );

  // ---------------- scoreboard state ----------------
  logic [DATA_W-1:0] exp_q[$];
  int                exp_cyc_q[$];
  bulk_exp_t         bulk_exp_q[$];
  int checks   = 0;
  int failures = 0;
  int bulk_valid_cycles = 0;
  int wb_hold_cycles    = 0;

  task automatic chk(input string name, input logic [LINE_BITS-1:0] act,
                     input logic [LINE_BITS-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Refill pattern returned by the adapter model: word 0 is zero, word w is
  // {line_addr - 0x1000, 0xAAAA_0000 | w}.
  function automatic logic [DATA_W-1:0] ref_word(input logic [ADDR_W-1:0] a, input int w);
    logic [31:0] hi;
    hi = a - 32'h1000;
    return (w == 0) ? 64'd0 : {hi, 32'hAAAA_0000 | 32'(w)};
  endfunction

  function automatic logic [LINE_BITS-1:0] ref_line(input logic [ADDR_W-1:0] a);
    logic [LINE_BITS-1:0] l;
    for (int w = 0; w < LINE_WORDS; w++) l[w*DATA_W +: DATA_W] = ref_word(a, w);
    return l;
  endfunction

  // ---------------- bulk adapter model ----------------
  int                stall_cnt = 0;
  bit                suppress  = 1'b0;
  int                pend      = 0;
  logic              hs_write  = 1'b0;
  logic [ADDR_W-1:0] hs_addr   = '0;

  initial begin
    bulk_if.bulk_req_ready  = 1'b0;
    bulk_if.bulk_resp_valid = 1'b0;
    bulk_if.bulk_resp_rdata = '0;
  end

  always @(posedge clk) begin
    #1;
    if (rst) begin
      bulk_if.bulk_req_ready  = 1'b0;
      bulk_if.bulk_resp_valid = 1'b0;
      pend = 0;
    end else begin
      bulk_if.bulk_resp_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0 && !suppress) begin
          bulk_if.bulk_resp_valid = 1'b1;
          bulk_if.bulk_resp_rdata = ref_line(hs_addr);
        end
      end
      if (bulk_if.bulk_req_ready) begin
        // Handshake completed on the edge just past.
        bulk_if.bulk_req_ready = 1'b0;
        if (!hs_write) pend = 3;
      end else if (bulk_if.bulk_req_valid) begin
        if (stall_cnt > 0) stall_cnt--;
        else begin
          bulk_if.bulk_req_ready = 1'b1;
          hs_write = bulk_if.bulk_req_write;
          hs_addr  = bulk_if.bulk_req_addr;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  bit        hold_prev = 1'b0;
  bulk_exp_t held;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (cpu_if.cpu_resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 1, 0);
        end else begin
          logic [DATA_W-1:0] e;
          int c;
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          chk("resp_rdata", cpu_if.cpu_resp_rdata, e);
          if (c >= 0) chk("resp_latency", cyc, c);
        end
      end
      if (bulk_if.bulk_req_valid) begin
        bulk_exp_t cur;
        cur = '{bulk_if.bulk_req_write, bulk_if.bulk_req_addr,
                bulk_if.bulk_req_wdata, bulk_if.bulk_req_wstrb};
        bulk_valid_cycles++;
        chk("cpu_ready_during_bulk", cpu_if.cpu_req_ready, 0);
        if (hold_prev) chk("bulk_fields_stable", cur, held);
        if (!bulk_if.bulk_req_ready && cur.write) wb_hold_cycles++;
        held      = cur;
        hold_prev = !bulk_if.bulk_req_ready;
        if (bulk_if.bulk_req_ready) begin
          if (bulk_exp_q.size() == 0) begin
            chk("bulk_unexpected", 1, 0);
          end else begin
            bulk_exp_t e;
            e = bulk_exp_q.pop_front();
            chk("bulk_write", cur.write, e.write);
            chk("bulk_addr", cur.addr, e.addr);
            chk("bulk_wdata", cur.wdata, e.wdata);
            chk("bulk_wstrb", cur.wstrb, e.wstrb);
          end
        end
      end else begin
        if (hold_prev) chk("bulk_valid_dropped", 0, 1);
        hold_prev = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_bulk(input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [LINE_BITS-1:0] d, input logic [LINE_STRB_W-1:0] s);
    bulk_exp_t e;
    e = '{wr, a, d, s};
    bulk_exp_q.push_back(e);
  endtask

  task automatic cpu_access(input logic wr, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] wd, input logic [STRB_W-1:0] ws,
                            input logic [DATA_W-1:0] exp_data, input bit exp_resp,
                            input bit chk_lat);
    bit ok;
    @(posedge clk); #1;
    cpu_if.cpu_req_valid = 1'b1;
    cpu_if.cpu_req_write = wr;
    cpu_if.cpu_req_addr  = a;
    cpu_if.cpu_req_wdata = wd;
    cpu_if.cpu_req_wstrb = ws;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (cpu_if.cpu_req_ready) ok = 1'b1;
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
    end else if (exp_resp) begin
      exp_q.push_back(exp_data);
      exp_cyc_q.push_back(chk_lat ? cyc + 2 : -1);
    end
    @(posedge clk); #1;
    cpu_if.cpu_req_valid = 1'b0;
    cpu_if.cpu_req_write = 1'b0;
    cpu_if.cpu_req_wdata = '0;
    cpu_if.cpu_req_wstrb = '0;
    if (ok && exp_resp) begin
      ok = 1'b0;
      for (int n = 0; n < 300 && !ok; n++) begin
        @(negedge clk); #1;
        if (exp_q.size() == 0) ok = 1'b1;
      end
      if (!ok) chk("resp_timeout", 0, 1);
      else if (chk_lat) begin
        @(negedge clk);
        chk("ready_after_hit", cpu_if.cpu_req_ready, 1);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int snap;
    bit ok;
    logic [LINE_BITS-1:0] line;
    cpu_if.cpu_req_valid = 1'b0;
    cpu_if.cpu_req_write = 1'b0;
    cpu_if.cpu_req_addr  = '0;
    cpu_if.cpu_req_wdata = '0;
    cpu_if.cpu_req_wstrb = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_ready", cpu_if.cpu_req_ready, 0);
    chk("rst_resp_valid", cpu_if.cpu_resp_valid, 0);
    chk("rst_bulk_valid", bulk_if.bulk_req_valid, 0);
    chk("rst_bulk_addr", bulk_if.bulk_req_addr, 0);
    chk("rst_state", state, S_IDLE);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("post_rst_ready", cpu_if.cpu_req_ready, 1);

    // Cold load: refill read, no writeback
    push_bulk(1'b0, 32'h0000_1000, '0, '0);
    cpu_access(1'b0, 32'h0000_1008, '0, '0, 64'h0000_0000_AAAA_0001, 1'b1, 1'b0);

    // Load hit: 2-cycle latency, no bulk traffic
    snap = bulk_valid_cycles;
    cpu_access(1'b0, 32'h0000_1010, '0, '0, 64'h0000_0000_AAAA_0002, 1'b1, 1'b1);
    chk("hit_no_bulk", bulk_valid_cycles, snap);

    // Store hit with partial strobe
    cpu_access(1'b1, 32'h0000_1000, 64'h1122_3344_5566_7788, 8'h0F,
               64'h0000_0000_5566_7788, 1'b1, 1'b1);

    // Conflict load: dirty writeback (stalled 5 cycles) then refill
    line = ref_line(32'h0000_1000);
    line[63:0] = 64'h0000_0000_5566_7788;
    push_bulk(1'b1, 32'h0000_1000, line, '1);
    push_bulk(1'b0, 32'h0000_1400, '0, '0);
    snap = wb_hold_cycles;
    stall_cnt = 5;
    cpu_access(1'b0, 32'h0000_1400, '0, '0, 64'h0, 1'b1, 1'b0);
    chk("wb_stall_cycles", wb_hold_cycles - snap, 5);
    cpu_access(1'b0, 32'h0000_1418, '0, '0, 64'h0000_0400_AAAA_0003, 1'b1, 1'b1);

    // Store miss on a clean victim: allocate, merge on replay
    push_bulk(1'b0, 32'h0000_2000, '0, '0);
    cpu_access(1'b1, 32'h0000_2008, 64'hDEAD_BEEF_0000_0000, 8'hF0,
               64'hDEAD_BEEF_AAAA_0001, 1'b1, 1'b0);

    // The allocated line is dirty: next conflict writes it back
    line = ref_line(32'h0000_2000);
    line[127:64] = 64'hDEAD_BEEF_AAAA_0001;
    push_bulk(1'b1, 32'h0000_2000, line, '1);
    push_bulk(1'b0, 32'h0000_1000, '0, '0);
    cpu_access(1'b0, 32'h0000_1000, '0, '0, 64'h0, 1'b1, 1'b0);

    // Reset while waiting for a refill
    suppress = 1'b1;
    push_bulk(1'b0, 32'h0000_0040, '0, '0);
    cpu_access(1'b0, 32'h0000_0048, '0, '0, 64'h0, 1'b0, 1'b0);
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (state == S_FILL_WAIT) ok = 1'b1;
    end
    chk("reach_fill_wait", ok, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_cpu_ready", cpu_if.cpu_req_ready, 0);
    chk("midrst_resp_valid", cpu_if.cpu_resp_valid, 0);
    chk("midrst_bulk_valid", bulk_if.bulk_req_valid, 0);
    chk("midrst_state", state, S_IDLE);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    suppress = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("midrst_ready_after", cpu_if.cpu_req_ready, 1);
    chk("midrst_bulk_drained", bulk_exp_q.size(), 0);

    // Same address misses again after reset
    push_bulk(1'b0, 32'h0000_0040, '0, '0);
    cpu_access(1'b0, 32'h0000_0048, '0, '0, 64'hFFFF_F040_AAAA_0001, 1'b1, 1'b0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("end_resp_queue_empty", exp_q.size(), 0);
    chk("end_bulk_queue_empty", bulk_exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
